// File: rtl/sc_pointsdisplay_if.sv
// sc_pointsdisplay_if: points bus and display outputs; PlayerLose_inLow exists only with SC_POINTSDISPLAY_BLINK_EN
interface sc_pointsdisplay_if;
  logic [5:0] SC_POINTSDISPLAY_Points_InBus;
  logic [7:0] SC_POINTSDISPLAY_BCD_OutBus;
  logic [6:0] SC_POINTSDISPLAY_HEX1_OutBus;
  logic [6:0] SC_POINTSDISPLAY_HEX0_OutBus;
  logic SC_POINTSDISPLAY_Busy_Out;
  logic SC_POINTSDISPLAY_Update_Out;
`ifdef SC_POINTSDISPLAY_BLINK_EN
  logic SC_POINTSDISPLAY_PlayerLose_inLow;
  modport master (
    output SC_POINTSDISPLAY_Points_InBus, SC_POINTSDISPLAY_PlayerLose_inLow,
    input SC_POINTSDISPLAY_BCD_OutBus, SC_POINTSDISPLAY_HEX1_OutBus, SC_POINTSDISPLAY_HEX0_OutBus,
    input SC_POINTSDISPLAY_Busy_Out, SC_POINTSDISPLAY_Update_Out
  );
  modport slave (
    input SC_POINTSDISPLAY_Points_InBus, SC_POINTSDISPLAY_PlayerLose_inLow,
    output SC_POINTSDISPLAY_BCD_OutBus, SC_POINTSDISPLAY_HEX1_OutBus, SC_POINTSDISPLAY_HEX0_OutBus,
    output SC_POINTSDISPLAY_Busy_Out, SC_POINTSDISPLAY_Update_Out
  );
`else
  modport master (
    output SC_POINTSDISPLAY_Points_InBus,
    input SC_POINTSDISPLAY_BCD_OutBus, SC_POINTSDISPLAY_HEX1_OutBus, SC_POINTSDISPLAY_HEX0_OutBus,
    input SC_POINTSDISPLAY_Busy_Out, SC_POINTSDISPLAY_Update_Out
  );
  modport slave (
    input SC_POINTSDISPLAY_Points_InBus,
    output SC_POINTSDISPLAY_BCD_OutBus, SC_POINTSDISPLAY_HEX1_OutBus, SC_POINTSDISPLAY_HEX0_OutBus,
    output SC_POINTSDISPLAY_Busy_Out, SC_POINTSDISPLAY_Update_Out
  );
`endif
endinterface

// File: rtl/sc_pointsdisplay.sv
// sc_pointsdisplay: change-triggered double-dabble points to two 7-seg digits; optional lose blink via SC_POINTSDISPLAY_BLINK_EN
module sc_pointsdisplay #(
  parameter int LEADING_ZERO_BLANK = 1
`ifdef SC_POINTSDISPLAY_BLINK_EN
  , parameter int BLINK_DIV = 25000000
`endif
) (
  input logic SC_POINTSCOUNTER_CLOCK_50,
  input logic SC_POINTSCOUNTER_RESET_InHigh,
  sc_pointsdisplay_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] TENS_RESET = (LEADING_ZERO_BLANK != 0) ? BLANK : 7'b1000000;
  state_t state;
  logic [5:0] lastValue;
  logic [13:0] shiftReg;
  logic [13:0] adjusted;
  logic [2:0] iterCount;
  logic [7:0] bcdReg;
  logic [6:0] hex1Reg;
  logic [6:0] hex0Reg;
  logic busyReg;
  logic updateReg;
  logic blank;
  function automatic logic [6:0] segOf(input logic [3:0] d);
    case (d)
      4'd0: segOf = 7'b1000000;
      4'd1: segOf = 7'b1111001;
      4'd2: segOf = 7'b0100100;
      4'd3: segOf = 7'b0110000;
      4'd4: segOf = 7'b0011001;
      4'd5: segOf = 7'b0010010;
      4'd6: segOf = 7'b0000010;
      4'd7: segOf = 7'b1111000;
      4'd8: segOf = 7'b0000000;
      4'd9: segOf = 7'b0010000;
      default: segOf = BLANK;
    endcase
  endfunction
  // add-3 correction on each BCD nibble ahead of the next shift
  always_comb begin
    adjusted = {
      (shiftReg[13:10] >= 4'd5) ? shiftReg[13:10] + 4'd3 : shiftReg[13:10],
      (shiftReg[9:6] >= 4'd5) ? shiftReg[9:6] + 4'd3 : shiftReg[9:6],
      shiftReg[5:0]
    };
  end
  // conversion FSM: watch for a new value, shift six times, then publish digits
  always_ff @(posedge SC_POINTSCOUNTER_CLOCK_50 or posedge SC_POINTSCOUNTER_RESET_InHigh) begin
    if (SC_POINTSCOUNTER_RESET_InHigh) begin
      state <= IDLE;
      lastValue <= '0;
      shiftReg <= '0;
      iterCount <= '0;
      bcdReg <= '0;
      hex1Reg <= TENS_RESET;
      hex0Reg <= 7'b1000000;
      busyReg <= 1'b0;
      updateReg <= 1'b0;
    end else begin
      updateReg <= 1'b0;
      case (state)
        IDLE: if (bus.SC_POINTSDISPLAY_Points_InBus != lastValue) begin
          shiftReg <= {8'b0, bus.SC_POINTSDISPLAY_Points_InBus};
          lastValue <= bus.SC_POINTSDISPLAY_Points_InBus;
          iterCount <= '0;
          busyReg <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: begin
          shiftReg <= adjusted << 1;
          iterCount <= iterCount + 3'd1;
          if (iterCount == 3'd5) state <= UPDATE;
        end
        UPDATE: begin
          bcdReg <= shiftReg[13:6];
          hex1Reg <= (LEADING_ZERO_BLANK != 0 && shiftReg[13:10] == 4'd0) ? BLANK : segOf(shiftReg[13:10]);
          hex0Reg <= segOf(shiftReg[9:6]);
          updateReg <= 1'b1;
          busyReg <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef SC_POINTSDISPLAY_BLINK_EN
  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [CW-1:0] blinkCount;
  logic blinkPhase;
  // while the player has lost, flip the blank phase every BLINK_DIV cycles
  always_ff @(posedge SC_POINTSCOUNTER_CLOCK_50 or posedge SC_POINTSCOUNTER_RESET_InHigh) begin
    if (SC_POINTSCOUNTER_RESET_InHigh || bus.SC_POINTSDISPLAY_PlayerLose_inLow) begin
      blinkCount <= '0;
      blinkPhase <= 1'b0;
    end else if (blinkCount == CW'(BLINK_DIV - 1)) begin
      blinkCount <= '0;
      blinkPhase <= ~blinkPhase;
    end else begin
      blinkCount <= blinkCount + CW'(1);
    end
  end
  assign blank = blinkPhase;
`else
  assign blank = 1'b0;
`endif
  assign bus.SC_POINTSDISPLAY_BCD_OutBus = bcdReg;
  assign bus.SC_POINTSDISPLAY_HEX1_OutBus = blank ? BLANK : hex1Reg;
  assign bus.SC_POINTSDISPLAY_HEX0_OutBus = blank ? BLANK : hex0Reg;
  assign bus.SC_POINTSDISPLAY_Busy_Out = busyReg;
  assign bus.SC_POINTSDISPLAY_Update_Out = updateReg;
endmodule

// File: tb/tb_sc_pointsdisplay.sv
// tb_sc_pointsdisplay: directed and random points values checked against an arithmetic BCD/segment model
module tb_sc_pointsdisplay;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int compared = 0;
  int mismatched = 0;
  logic [5:0] modelLast = '0;
  logic [6:0] segTab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  sc_pointsdisplay_if bus();
  sc_pointsdisplay_if bus2();
  always #5 clk = ~clk;
  sc_pointsdisplay #(
    .LEADING_ZERO_BLANK(1)
`ifdef SC_POINTSDISPLAY_BLINK_EN
    , .BLINK_DIV(4)
`endif
  ) dut (
    .SC_POINTSCOUNTER_CLOCK_50(clk),
    .SC_POINTSCOUNTER_RESET_InHigh(rst),
    .bus(bus)
  );
  sc_pointsdisplay #(
    .LEADING_ZERO_BLANK(0)
`ifdef SC_POINTSDISPLAY_BLINK_EN
    , .BLINK_DIV(4)
`endif
  ) dutNoBlank (
    .SC_POINTSCOUNTER_CLOCK_50(clk),
    .SC_POINTSCOUNTER_RESET_InHigh(rst),
    .bus(bus2)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [7:0] expBcd(input logic [5:0] v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction
  function automatic logic [6:0] expHex1(input logic [5:0] v, input bit lzb);
    return (lzb && v < 10) ? 7'b1111111 : segTab[v / 10];
  endfunction
  function automatic logic [6:0] expHex0(input logic [5:0] v);
    return segTab[v % 10];
  endfunction
  task automatic setPoints(input logic [5:0] v);
    bus.SC_POINTSDISPLAY_Points_InBus = v;
    bus2.SC_POINTSDISPLAY_Points_InBus = v;
  endtask
  task automatic checkDisplay(input string tag);
    chk({tag, ".bcd"}, bus.SC_POINTSDISPLAY_BCD_OutBus, expBcd(modelLast));
    chk({tag, ".hex1"}, bus.SC_POINTSDISPLAY_HEX1_OutBus, expHex1(modelLast, 1'b1));
    chk({tag, ".hex0"}, bus.SC_POINTSDISPLAY_HEX0_OutBus, expHex0(modelLast));
    chk({tag, ".hex1_nolzb"}, bus2.SC_POINTSDISPLAY_HEX1_OutBus, expHex1(modelLast, 1'b0));
  endtask
  task automatic checkReset(input string tag);
    chk({tag, ".bcd"}, bus.SC_POINTSDISPLAY_BCD_OutBus, 8'h00);
    chk({tag, ".hex0"}, bus.SC_POINTSDISPLAY_HEX0_OutBus, 7'b1000000);
    chk({tag, ".hex1"}, bus.SC_POINTSDISPLAY_HEX1_OutBus, 7'b1111111);
    chk({tag, ".hex1_nolzb"}, bus2.SC_POINTSDISPLAY_HEX1_OutBus, 7'b1000000);
    chk({tag, ".busy"}, bus.SC_POINTSDISPLAY_Busy_Out, 1'b0);
    chk({tag, ".update"}, bus.SC_POINTSDISPLAY_Update_Out, 1'b0);
  endtask
  task automatic convert(input logic [5:0] v);
    bit changes;
    changes = (v != modelLast);
    setPoints(v);
    for (int i = 0; i < 9; i++) begin
      step();
      chk("busy", bus.SC_POINTSDISPLAY_Busy_Out, changes && i < 7);
      chk("update", bus.SC_POINTSDISPLAY_Update_Out, changes && i == 7);
      if (i < 7) chk("hold.bcd", bus.SC_POINTSDISPLAY_BCD_OutBus, expBcd(modelLast));
    end
    modelLast = v;
    checkDisplay("conv");
  endtask
  initial begin
    int ups;
    bit prevUp;
    logic [7:0] got [2];
    setPoints(6'd0);
`ifdef SC_POINTSDISPLAY_BLINK_EN
    bus.SC_POINTSDISPLAY_PlayerLose_inLow = 1'b1;
    bus2.SC_POINTSDISPLAY_PlayerLose_inLow = 1'b1;
`endif
    step();
    step();
    checkReset("reset");
    rst = 1'b0;
    convert(6'd37);
    convert(6'd9);
    convert(6'd10);
    convert(6'd10);
    convert(6'd63);
    convert(6'd0);
    // change applied in the third busy cycle is picked up by a second conversion
    setPoints(6'd12);
    step();
    step();
    step();
    chk("midchange.busy", bus.SC_POINTSDISPLAY_Busy_Out, 1'b1);
    setPoints(6'd45);
    ups = 0;
    prevUp = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (prevUp && ups == 1) chk("midchange.restart", bus.SC_POINTSDISPLAY_Busy_Out, 1'b1);
      prevUp = bus.SC_POINTSDISPLAY_Update_Out;
      if (bus.SC_POINTSDISPLAY_Update_Out) begin
        if (ups < 2) got[ups] = bus.SC_POINTSDISPLAY_BCD_OutBus;
        ups++;
      end
    end
    chk("midchange.pulses", ups, 2);
    chk("midchange.first", got[0], expBcd(6'd12));
    chk("midchange.second", got[1], expBcd(6'd45));
    modelLast = 6'd45;
    checkDisplay("midchange");
    // reset in the fourth busy cycle aborts the conversion without a pulse
    setPoints(6'd50);
    for (int i = 0; i < 4; i++) step();
    chk("abort.busy", bus.SC_POINTSDISPLAY_Busy_Out, 1'b1);
    rst = 1'b1;
    #1;
    checkReset("abort");
    ups = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.SC_POINTSDISPLAY_Update_Out) ups++;
    end
    chk("abort.pulses", ups, 0);
    rst = 1'b0;
    modelLast = 6'd0;
    convert(6'd50);
    for (int i = 0; i < 20; i++) convert(6'($urandom_range(0, 63)));
`ifdef SC_POINTSDISPLAY_BLINK_EN
    convert(6'd63);
    bus.SC_POINTSDISPLAY_PlayerLose_inLow = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      step();
      chk("blink.hex1", bus.SC_POINTSDISPLAY_HEX1_OutBus, ((k / 4) % 2) ? 7'b1111111 : 7'b0000010);
      chk("blink.hex0", bus.SC_POINTSDISPLAY_HEX0_OutBus, ((k / 4) % 2) ? 7'b1111111 : 7'b0110000);
      chk("blink.bcd", bus.SC_POINTSDISPLAY_BCD_OutBus, 8'h63);
    end
    bus.SC_POINTSDISPLAY_PlayerLose_inLow = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("steady.hex1", bus.SC_POINTSDISPLAY_HEX1_OutBus, 7'b0000010);
      chk("steady.hex0", bus.SC_POINTSDISPLAY_HEX0_OutBus, 7'b0110000);
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
